// File: rtl/tug_rope_fsm.sv
// -----------------------------------------------------------------------------
// tug_rope_fsm
//
// Game core of the tug-of-war design. Converts the two players' debounced
// button levels into a rope position shown on a 7-LED bar, detects a win on
// either side and emits a single-cycle wingame pulse for the cheer animation.
//
// Parameters:
//   LOCKOUT_TICKS  slowen512 strobes during which both buttons are ignored
//                  after an accepted pull (0..15, 0 disables the lockout).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   slowen512  in   one-clk-wide 512 Hz strobe, paces the lockout counter
//   pbl        in   left button, debounced level, synchronous to clk
//   pbr        in   right button, debounced level, synchronous to clk
//   score      out  [6:0] rope LED pattern, bit 6 = leftmost LED
//   wingame    out  one-cycle pulse when a win is declared
//   winner     out  1 = right won, 0 = left won (meaningful in WIN only)
// -----------------------------------------------------------------------------
module tug_rope_fsm #(
   parameter int LOCKOUT_TICKS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       slowen512,
   input  logic       pbl,
   input  logic       pbr,
   output logic [6:0] score,
   output logic       wingame,
   output logic       winner
);

   localparam logic [1:0] ST_PLAY = 2'd0;
   localparam logic [1:0] ST_LOCK = 2'd1;
   localparam logic [1:0] ST_WIN  = 2'd2;

   localparam logic [3:0] LOCK_LOAD = 4'(LOCKOUT_TICKS);
   localparam logic       LOCK_EN   = (LOCKOUT_TICKS != 0);

   localparam logic [2:0] POS_RESET = 3'd3;
   localparam logic [2:0] POS_LEFT_WIN  = 3'd6;
   localparam logic [2:0] POS_RIGHT_WIN = 3'd0;

   localparam logic [6:0] SCORE_RESET     = 7'b0001000;
   localparam logic [6:0] SCORE_LEFT_WIN  = 7'b1110000;
   localparam logic [6:0] SCORE_RIGHT_WIN = 7'b0000111;

   logic [1:0] state_reg,    state_next;
   logic [2:0] pos_reg,      pos_next;
   logic [6:0] score_reg,    score_next;
   logic       wingame_reg,  wingame_next;
   logic       winner_reg,   winner_next;
   logic [3:0] lock_cnt_reg, lock_cnt_next;

   // Previous button levels; reset to 1 so a button held through reset
   // does not register as a press when reset is released.
   logic       pbl_q;
   logic       pbr_q;

   logic       press_l;
   logic       press_r;
   logic       pull_valid;
   logic [2:0] pull_pos;
   logic [6:0] pos_onehot;

   assign press_l    = pbl & ~pbl_q;
   assign press_r    = pbr & ~pbr_q;
   // Simultaneous presses cancel out: neither side gains ground.
   assign pull_valid = press_l ^ press_r;

   always_comb begin
      pull_pos = pos_reg;
      if (press_l && !press_r) begin
         pull_pos = pos_reg + 3'd1;
      end else if (press_r && !press_l) begin
         pull_pos = pos_reg - 3'd1;
      end
   end

   // LED decode of the candidate position; only used for positions 1..5,
   // the end positions have their own wide "victory" patterns.
   genvar gi;
   generate
      for (gi = 0; gi < 7; gi = gi + 1) begin : g_onehot
         assign pos_onehot[gi] = (pull_pos == 3'(gi));
      end
   endgenerate

   always_comb begin
      state_next    = state_reg;
      pos_next      = pos_reg;
      score_next    = score_reg;
      winner_next   = winner_reg;
      lock_cnt_next = lock_cnt_reg;
      wingame_next  = 1'b0;

      case (state_reg)
         ST_PLAY: begin
            if (pull_valid) begin
               pos_next = pull_pos;
               if (pull_pos == POS_LEFT_WIN) begin
                  state_next   = ST_WIN;
                  score_next   = SCORE_LEFT_WIN;
                  winner_next  = 1'b0;
                  wingame_next = 1'b1;
               end else if (pull_pos == POS_RIGHT_WIN) begin
                  state_next   = ST_WIN;
                  score_next   = SCORE_RIGHT_WIN;
                  winner_next  = 1'b1;
                  wingame_next = 1'b1;
               end else begin
                  score_next    = pos_onehot;
                  lock_cnt_next = LOCK_LOAD;
                  state_next    = LOCK_EN ? ST_LOCK : ST_PLAY;
               end
            end
         end

         ST_LOCK: begin
            // Presses are dropped here; the edge registers still track the
            // buttons so a held button cannot fire once the lock expires.
            if (slowen512) begin
               if (lock_cnt_reg <= 4'd1) begin
                  lock_cnt_next = 4'd0;
                  state_next    = ST_PLAY;
               end else begin
                  lock_cnt_next = lock_cnt_reg - 4'd1;
               end
            end
         end

         ST_WIN: begin
            // Terminal until reset; everything frozen.
         end

         default: begin
            state_next = ST_PLAY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_PLAY;
         pos_reg      <= POS_RESET;
         score_reg    <= SCORE_RESET;
         wingame_reg  <= 1'b0;
         winner_reg   <= 1'b0;
         lock_cnt_reg <= 4'd0;
         pbl_q        <= 1'b1;
         pbr_q        <= 1'b1;
      end else begin
         state_reg    <= state_next;
         pos_reg      <= pos_next;
         score_reg    <= score_next;
         wingame_reg  <= wingame_next;
         winner_reg   <= winner_next;
         lock_cnt_reg <= lock_cnt_next;
         pbl_q        <= pbl;
         pbr_q        <= pbr;
      end
   end

   assign score   = score_reg;
   assign wingame = wingame_reg;
   assign winner  = winner_reg;

endmodule

// File: tb/tb_tug_rope_fsm.sv
module tb_tug_rope_fsm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance with no lockout (table-driven vectors)
   logic       rst0 = 1'b1, slow0 = 1'b0, pbl0 = 1'b0, pbr0 = 1'b0;
   logic [6:0] score0;
   logic       wg0, win0;

   // Instance with LOCKOUT_TICKS = 4 (hand-written sequence)
   logic       rst4 = 1'b1, slow4 = 1'b0, pbl4 = 1'b0, pbr4 = 1'b0;
   logic [6:0] score4;
   logic       wg4, win4;

   tug_rope_fsm #(.LOCKOUT_TICKS(0)) dut0 (
      .clk(clk), .rst(rst0), .slowen512(slow0), .pbl(pbl0), .pbr(pbr0),
      .score(score0), .wingame(wg0), .winner(win0)
   );

   tug_rope_fsm #(.LOCKOUT_TICKS(4)) dut4 (
      .clk(clk), .rst(rst4), .slowen512(slow4), .pbl(pbl4), .pbr(pbr4),
      .score(score4), .wingame(wg4), .winner(win4)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       rst;
      logic       pbl;
      logic       pbr;
      logic       slow;
      logic [6:0] score;
      logic       wg;
      logic       win;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, input logic l, input logic rr, input logic s,
                      input logic [6:0] sc, input logic w, input logic wn);
      vec_t v;
      v.rst = r; v.pbl = l; v.pbr = rr; v.slow = s;
      v.score = sc; v.wg = w; v.win = wn;
      vq.push_back(v);
   endtask

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // One cycle on the lockout instance: drive, clock, check score/wingame/winner
   task automatic step4(input string name, input logic r, input logic l, input logic rr,
                        input logic s, input logic [6:0] sc, input logic w, input logic wn);
      rst4 = r; pbl4 = l; pbr4 = rr; slow4 = s;
      @(posedge clk); #1;
      $display("lock4 %s: rst=%b pbl=%b pbr=%b slow=%b -> score=%b wingame=%b winner=%b",
               name, r, l, rr, s, score4, wg4, win4);
      check({name, ".score"}, score4, sc);
      check({name, ".wingame"}, {6'd0, wg4}, {6'd0, w});
      check({name, ".winner"}, {6'd0, win4}, {6'd0, wn});
   endtask

   initial begin
      // ---------------- table for LOCKOUT_TICKS = 0 ----------------
      //   rst  pbl  pbr  slow  score        wg   win
      add(1'b1, 1'b1, 1'b0, 1'b0, 7'b0001000, 1'b0, 1'b0); // reset, pbl held
      add(1'b0, 1'b1, 1'b0, 1'b0, 7'b0001000, 1'b0, 1'b0); // held through reset: no press
      add(1'b0, 1'b0, 1'b0, 1'b0, 7'b0001000, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b1, 7'b0010000, 1'b0, 1'b0); // left -> pos4
      add(1'b0, 1'b0, 1'b0, 1'b0, 7'b0010000, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 7'b0100000, 1'b0, 1'b0); // pos5
      add(1'b0, 1'b0, 1'b0, 1'b0, 7'b0100000, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 7'b1110000, 1'b1, 1'b0); // left wins
      add(1'b0, 1'b0, 1'b0, 1'b0, 7'b1110000, 1'b0, 1'b0); // pulse is one cycle
      add(1'b0, 1'b1, 1'b0, 1'b0, 7'b1110000, 1'b0, 1'b0); // frozen
      add(1'b0, 1'b0, 1'b1, 1'b0, 7'b1110000, 1'b0, 1'b0); // frozen
      add(1'b1, 1'b0, 1'b1, 1'b0, 7'b0001000, 1'b0, 1'b0); // reset out of WIN
      add(1'b0, 1'b0, 1'b0, 1'b0, 7'b0001000, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 7'b0001000, 1'b0, 1'b0); // tie
      add(1'b0, 1'b0, 1'b0, 1'b0, 7'b0001000, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 7'b0000100, 1'b0, 1'b0); // right -> pos2
      add(1'b0, 1'b0, 1'b0, 1'b0, 7'b0000100, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 7'b0000010, 1'b0, 1'b0); // pos1
      add(1'b0, 1'b0, 1'b0, 1'b0, 7'b0000010, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 7'b0000111, 1'b1, 1'b1); // right wins
      add(1'b0, 1'b0, 1'b0, 1'b0, 7'b0000111, 1'b0, 1'b1);
      add(1'b0, 1'b1, 1'b0, 1'b0, 7'b0000111, 1'b0, 1'b1); // frozen
      add(1'b1, 1'b1, 1'b0, 1'b0, 7'b0001000, 1'b0, 1'b0); // reset from WIN
      add(1'b0, 1'b0, 1'b0, 1'b0, 7'b0001000, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 7'b0010000, 1'b0, 1'b0); // pos4
      add(1'b0, 1'b0, 1'b0, 1'b0, 7'b0010000, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 7'b0100000, 1'b0, 1'b0); // pos5
      add(1'b0, 1'b0, 1'b0, 1'b0, 7'b0100000, 1'b0, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 7'b0001000, 1'b0, 1'b0); // rst beats winning press
      add(1'b0, 1'b0, 1'b0, 1'b0, 7'b0001000, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 7'b0010000, 1'b0, 1'b0); // play resumes

      for (int i = 0; i < vq.size(); i++) begin
         rst0 = vq[i].rst; pbl0 = vq[i].pbl; pbr0 = vq[i].pbr; slow0 = vq[i].slow;
         @(posedge clk); #1;
         $display("lock0 vec %0d: rst=%b pbl=%b pbr=%b slow=%b -> score=%b wingame=%b winner=%b",
                  i, vq[i].rst, vq[i].pbl, vq[i].pbr, vq[i].slow, score0, wg0, win0);
         check($sformatf("vec%0d.score", i), score0, vq[i].score);
         check($sformatf("vec%0d.wingame", i), {6'd0, wg0}, {6'd0, vq[i].wg});
         check($sformatf("vec%0d.winner", i), {6'd0, win0}, {6'd0, vq[i].win});
      end

      // ---------------- LOCKOUT_TICKS = 4 sequence ----------------
      step4("reset",       1'b1, 1'b0, 1'b0, 1'b0, 7'b0001000, 1'b0, 1'b0);
      step4("idle",        1'b0, 1'b0, 1'b0, 1'b0, 7'b0001000, 1'b0, 1'b0);
      // strobe in the pull cycle must not count
      step4("pull_left",   1'b0, 1'b1, 1'b0, 1'b1, 7'b0010000, 1'b0, 1'b0);
      step4("strobe1",     1'b0, 1'b0, 1'b0, 1'b1, 7'b0010000, 1'b0, 1'b0);
      step4("gap",         1'b0, 1'b0, 1'b0, 1'b0, 7'b0010000, 1'b0, 1'b0);
      step4("strobe2",     1'b0, 1'b0, 1'b0, 1'b1, 7'b0010000, 1'b0, 1'b0);
      step4("right_2str",  1'b0, 1'b0, 1'b1, 1'b0, 7'b0010000, 1'b0, 1'b0);
      step4("release",     1'b0, 1'b0, 1'b0, 1'b0, 7'b0010000, 1'b0, 1'b0);
      step4("strobe3",     1'b0, 1'b0, 1'b0, 1'b1, 7'b0010000, 1'b0, 1'b0);
      step4("right_3str",  1'b0, 1'b0, 1'b1, 1'b0, 7'b0010000, 1'b0, 1'b0);
      step4("release2",    1'b0, 1'b0, 1'b0, 1'b0, 7'b0010000, 1'b0, 1'b0);
      step4("strobe4",     1'b0, 1'b0, 1'b0, 1'b1, 7'b0010000, 1'b0, 1'b0);
      step4("right_4str",  1'b0, 1'b0, 1'b1, 1'b0, 7'b0001000, 1'b0, 1'b0);
      step4("release3",    1'b0, 1'b0, 1'b0, 1'b0, 7'b0001000, 1'b0, 1'b0);
      // now in LOCK again; a reset must drop straight back to PLAY
      step4("rst_in_lock", 1'b1, 1'b0, 1'b0, 1'b0, 7'b0001000, 1'b0, 1'b0);
      step4("after_rst",   1'b0, 1'b0, 1'b0, 1'b0, 7'b0001000, 1'b0, 1'b0);
      step4("press_free",  1'b0, 1'b1, 1'b0, 1'b0, 7'b0010000, 1'b0, 1'b0);
      // still locked immediately after that pull
      step4("release4",    1'b0, 1'b0, 1'b0, 1'b0, 7'b0010000, 1'b0, 1'b0);
      step4("locked_left", 1'b0, 1'b1, 1'b0, 1'b0, 7'b0010000, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tug_rope_fsm.md
# tug_rope_fsm

Game core of the tug-of-war design. It turns the two players' debounced push-button levels into a rope position shown as a 7-bit LED pattern (`score`). It detects when either side wins and raises a one-cycle `wingame` pulse. `score` and `wingame` feed the victory-cheer animation stage directly, which owns the LEDs after a win.

## Interface
Parameters:
- `LOCKOUT_TICKS`, default 4: number of `slowen512` strobes during which both buttons are ignored after any accepted pull. Legal range is 0..15; 0 means no lockout.

Ports:
- `clk`, input, 1: system clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `slowen512`, input, 1: one-`clk`-wide enable strobe at 512 Hz; used only for lockout timing.
- `pbl`, input, 1: left player button, debounced level, already synchronous to `clk`.
- `pbr`, input, 1: right player button, debounced level, already synchronous to `clk`.
- `score`, output, 7: rope LED pattern; bit 6 is the leftmost LED.
- `wingame`, output, 1: one-cycle pulse on the cycle a win is declared.
- `winner`, output, 1: 1 = right won, 0 = left won; valid only while in WIN.

## Operation
States:
- PLAY: the rope is live.
- LOCK: the rope is live, but presses are ignored while the lockout counter runs.
- WIN: terminal; the block stays here until `rst`.

Reset values:
- state = PLAY, pos = 3, `score` = 7'b0001000.
- `wingame` = 0, `winner` = 0, lockout counter = 0.
- Edge registers `pbl_q` and `pbr_q` = 1, so a button held through reset does not count as a press.

Press detection:
- A press is `pbl & ~pbl_q` (likewise for `pbr`).
- `pbl_q` and `pbr_q` update every cycle, in all states.

Pull rules, applied in PLAY only:
- Left press only: pos + 1.
- Right press only: pos − 1.
- Both pressed in the same cycle: tie; no move, no lockout.
- Neither pressed: no change.

After an accepted pull:
- If the new pos is 1..5: `score` = one-hot(pos), i.e. 1 << pos, lockout counter loads `LOCKOUT_TICKS`, and the state goes to LOCK. If `LOCKOUT_TICKS` = 0, the state stays in PLAY.
- If the new pos is 6 (left wins): state goes to WIN, `score` = 7'b1110000, `winner` = 0, and `wingame` = 1 for exactly one cycle.
- If the new pos is 0 (right wins): state goes to WIN, `score` = 7'b0000111, `winner` = 1, and `wingame` = 1 for exactly one cycle.

LOCK:
- The counter decrements on each cycle where `slowen512` = 1.
- When the counter is 1 and `slowen512` = 1, it reaches 0 and the state returns to PLAY on the same edge.
- Presses seen while in LOCK are discarded, not queued.

WIN:
- `score`, `winner` and pos are frozen.
- Buttons are ignored.
- `wingame` stays 0 after its single pulse.

Position arithmetic:
- pos is a 3-bit unsigned value, 0..6.
- pos can never leave the range, because reaching 0 or 6 ends the game.
- There is no wrap-around, and 7 is unreachable.

## Timing
- All outputs are registered.
- Latency: an input rising edge sampled at clock edge N updates `score` (and `wingame`, on a winning pull) at edge N, so they are visible during cycle N+1.
- `wingame` is high for exactly one `clk` cycle per game; the downstream stage restarts its animation on that pulse.
- Lockout duration is `LOCKOUT_TICKS` `slowen512` strobes, i.e. `LOCKOUT_TICKS`/512 s ± one strobe period.
- A `slowen512` strobe in the same cycle as the accepted pull does not decrement; counting starts on the next cycle.
- `rst` mid-game, in any state including LOCK and WIN, returns every output to its reset value on the next edge and has priority over any press in the same cycle.
- If `rst` is asserted in the same cycle a win would be declared, `wingame` is not pulsed.

## Test plan
- Reset with `pbl` held high, release, then press once -> `score` stays 7'b0001000 while held through reset; a single press after release gives 7'b0010000.
- `LOCKOUT_TICKS` = 0, three left presses spaced 2 clocks apart -> `score` steps 0010000, 0100000, then 1110000 with `wingame` high one cycle and `winner` = 0; further presses change nothing.
- Three right presses -> `score` steps 0000100, 0000010, then 0000111 with one `wingame` pulse and `winner` = 1.
- Simultaneous `pbl` and `pbr` rising edges at pos 3 -> `score` stays 7'b0001000; no lockout entered.
- `LOCKOUT_TICKS` = 4: left press, then a right press after 2 strobes -> right press ignored, `score` = 0010000; after 4 strobes a right press gives 0001000.
- `rst` asserted during LOCK and again during WIN -> next cycle `score` = 0001000, `wingame` = 0, `winner` = 0, and play resumes normally.
